// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//
// Data-memory bus between the load/store unit (master) and the data memory
// (slave). A request is held until acknowledged; the memory may insert any
// number of wait states before asserting bus_ack.
//
// Signals
//   bus_req   : master -> slave, access request, held until bus_ack
//   bus_we    : master -> slave, 1 = write, 0 = read
//   bus_addr  : master -> slave, word-aligned byte address
//   bus_be    : master -> slave, byte enables, bit i selects lane [8i+7:8i]
//   bus_wdata : master -> slave, lane-replicated write data
//   bus_rdata : slave -> master, read data, valid in the bus_ack cycle
//   bus_ack   : slave -> master, access complete
// -----------------------------------------------------------------------------
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Multi-cycle load/store unit between the execute stage and a data-memory bus
// with request/acknowledge handshake. Handles byte/halfword/word accesses,
// sign/zero extension on loads, byte-enable generation and lane replication on
// stores, alignment and fun3 legality checking, and a bus timeout. stall holds
// the PC from the request cycle until the access completes.
//
// Parameters
//   TIMEOUT    : REQ cycles without bus_ack before the access aborts (1..255)
//
// Ports
//   clk, reset : clock, asynchronous active-high reset
//   MemRead    : load request
//   MemWrite   : store request (wins over MemRead)
//   fun3       : access size / sign (instruction[14:12])
//   address    : byte address
//   store_data : store source data
//   load_data  : registered, extended load result
//   stall      : hold PC / pipeline inputs while high
//   misaligned : one-cycle pulse for a misaligned address or illegal fun3
//   bus_err    : one-cycle pulse in DONE when the access timed out
//   bus        : data-memory bus, master side
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [2:0]               fun3,
    input  logic [31:0]              address,
    input  logic [31:0]              store_data,
    output logic [31:0]              load_data,
    output logic                     stall,
    output logic                     misaligned,
    output logic                     bus_err,
    load_store_unit_if.master        bus
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_next;

    // Registered copies of the accepted request; they drive the bus in REQ.
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [1:0]  offset_q;
    logic [2:0]  fun3_q;

    logic [7:0]  wait_cnt;
    logic        err_flag;
    logic        req_o;

    logic        req_active;
    logic        fun3_legal;
    logic        aligned;
    logic        req_accept;
    logic        timeout_hit;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;

    // -------------------------------------------------------------------------
    // Request decode (IDLE inputs)
    // -------------------------------------------------------------------------
    assign req_active = MemRead | MemWrite;

    // NOTE: every signal written in an always_comb gets a value on every path
    // (defaults first or a full case) so no latch is inferred.
    always_comb begin
        // Loads: lb/lh/lbu/lhu (fun3[1:0] = 00/01 with either sign bit) and lw.
        if (MemWrite) fun3_legal = (fun3[2] == 1'b0) && (fun3[1:0] != 2'b11);
        else          fun3_legal = (fun3[1:0] == 2'b00) || (fun3[1:0] == 2'b01) ||
                                   (fun3 == 3'b010);
        case (fun3[1:0])
            2'b01:   aligned = ~address[0];
            2'b10:   aligned = (address[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign req_accept = req_active & fun3_legal & aligned;

    // Store lane generation; reads use all lanes with zero write data.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = '0;
        if (MemWrite) begin
            case (fun3[1:0])
                2'b00: begin
                    be_next    = 4'b0001 << address[1:0];
                    wdata_next = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be_next    = address[1] ? 4'b1100 : 4'b0011;
                    wdata_next = {2{store_data[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = store_data;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Load extraction from the registered byte offset and fun3
    // -------------------------------------------------------------------------
    assign rdata_shifted = bus.bus_rdata >> {offset_q, 3'b000};

    always_comb begin
        case (fun3_q)
            3'b000:  load_ext = {{24{rdata_shifted[7]}},  rdata_shifted[7:0]};
            3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_ext = {24'b0, rdata_shifted[7:0]};
            3'b101:  load_ext = {16'b0, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;   // lw, offset is always 0
        endcase
    end

    assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        misaligned = 1'b0;
        bus_err    = 1'b0;
        req_o      = 1'b0;
        case (state)
            IDLE: begin
                if (req_active) begin
                    if (req_accept) begin
                        stall      = 1'b1;
                        state_next = REQ;
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
            REQ: begin
                req_o = 1'b1;
                stall = 1'b1;
                if (bus.bus_ack || timeout_hit) state_next = DONE;
            end
            DONE: begin
                // Request inputs are ignored here, so the retiring
                // instruction cannot re-trigger an access.
                bus_err    = err_flag;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    // NOTE: the request copies are reset as well, so the bus outputs are
    // defined (all zero) from reset rather than only after the first access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            offset_q  <= '0;
            fun3_q    <= '0;
            wait_cnt  <= '0;
            err_flag  <= 1'b0;
            load_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_accept) begin
                        addr_q   <= {address[31:2], 2'b00};
                        we_q     <= MemWrite;
                        be_q     <= be_next;
                        wdata_q  <= wdata_next;
                        offset_q <= address[1:0];
                        fun3_q   <= fun3;
                        wait_cnt <= '0;
                        err_flag <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        if (!we_q) load_data <= load_ext;
                    end else if (timeout_hit) begin
                        err_flag  <= 1'b1;
                        load_data <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_req   = req_o;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

endmodule
